// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle for the write and read sides of stream_fifo.
// The FIFO takes the slave view; whatever feeds and drains it takes the master view.
interface stream_fifo_if #(
  parameter int WIDTH = 32
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO using all DEPTH entries (any DEPTH), with a registered or FWFT read side,
// almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow flags.
module stream_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  stream_fifo_if.slave               bus,
  input  logic                       clr_err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             push;
  logic             pop;
  logic             rd_valid_w;
  logic [WIDTH-1:0] rd_data_w;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign push = bus.wr_valid && !full;
  assign pop  = bus.rd_ready && !empty;

  assign bus.wr_ready = !full;
  assign bus.rd_valid = rd_valid_w;
  assign bus.rd_data  = rd_data_w;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wp] <= bus.wr_data;
    end
  end

  // Pointers wrap by explicit compare so non-power-of-two depths use every entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= (wp == LAST_P) ? '0 : wp + 1'b1;
      end
      if (pop) begin
        rp <= (rp == LAST_P) ? '0 : rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.wr_valid && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (bus.rd_ready && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Masked while empty so rd_data reads zero out of reset despite the unreset array.
      assign rd_valid_w = !empty;
      assign rd_data_w  = empty ? '0 : mem[rp];
    end else begin : g_registered
      logic             rd_valid_q;
      logic [WIDTH-1:0] rd_data_q;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          rd_valid_q <= pop;
          if (pop) begin
            rd_data_q <= mem[rp];
          end
        end
      end

      assign rd_valid_w = rd_valid_q;
      assign rd_data_w  = rd_data_q;
    end
  endgenerate
endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a DEPTH=5 registered-read instance and a DEPTH=4 FWFT instance
// with AF_LEVEL=3, AE_LEVEL=1, checked against hand-computed values.
module tb_stream_fifo;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;

  int checks   = 0;
  int failures = 0;

  stream_fifo_if #(.WIDTH(8)) ifa ();
  stream_fifo_if #(.WIDTH(8)) ifb ();

  logic [2:0] count_a;
  logic [2:0] count_b;
  logic full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic full_b, empty_b, af_b, ae_b, ovf_b, unf_b;

  always #5 CLK = ~CLK;

  stream_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(0)) dut_a (
    .CLK(CLK), .RST(RST), .bus(ifa), .clr_err(clr_a), .count(count_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  stream_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut_b (
    .CLK(CLK), .RST(RST), .bus(ifb), .clr_err(clr_b), .count(count_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle on the selected instance (0 = A, 1 = B), the other idles; returns 1ns after the edge.
  task automatic applyStimulus(input bit sel, input logic wv, input logic [7:0] wd, input logic rr, input logic clr);
    ifa.wr_valid = sel ? 1'b0 : wv;
    ifa.wr_data  = sel ? 8'h00 : wd;
    ifa.rd_ready = sel ? 1'b0 : rr;
    clr_a        = sel ? 1'b0 : clr;
    ifb.wr_valid = sel ? wv : 1'b0;
    ifb.wr_data  = sel ? wd : 8'h00;
    ifb.rd_ready = sel ? rr : 1'b0;
    clr_b        = sel ? clr : 1'b0;
    @(posedge CLK);
    #1;
    ifa.wr_valid = 1'b0;
    ifa.rd_ready = 1'b0;
    ifb.wr_valid = 1'b0;
    ifb.rd_ready = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    ifa.wr_valid = 1'b0; ifa.wr_data = 8'h00; ifa.rd_ready = 1'b0;
    ifb.wr_valid = 1'b0; ifb.wr_data = 8'h00; ifb.rd_ready = 1'b0;
    #3;
    checkOutput("rst_count_a", 32'(count_a), 0);
    checkOutput("rst_empty_a", 32'(empty_a), 1);
    checkOutput("rst_full_a", 32'(full_a), 0);
    checkOutput("rst_ae_a", 32'(ae_a), 1);
    checkOutput("rst_af_a", 32'(af_a), 0);
    checkOutput("rst_rdv_a", 32'(ifa.rd_valid), 0);
    checkOutput("rst_rdd_a", 32'(ifa.rd_data), 0);
    checkOutput("rst_wrr_a", 32'(ifa.wr_ready), 1);
    checkOutput("rst_flags_a", {30'd0, ovf_a, unf_a}, 0);
    checkOutput("rst_rdv_b", 32'(ifb.rd_valid), 0);
    checkOutput("rst_rdd_b", 32'(ifb.rd_data), 0);
    checkOutput("rst_ae_b", 32'(ae_b), 1);
    #9 RST = 1'b0;

    // FWFT instance: word visible the cycle after its push, with no rd_ready.
    applyStimulus(1, 1, 8'hA5, 0, 0);
    checkOutput("fwft_rdv", 32'(ifb.rd_valid), 1);
    checkOutput("fwft_rdd", 32'(ifb.rd_data), 32'hA5);
    checkOutput("fwft_cnt1", 32'(count_b), 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 8'h00, 0, 0);
      checkOutput("fwft_hold", 32'(ifb.rd_data), 32'hA5);
    end
    applyStimulus(1, 0, 8'h00, 1, 0);
    checkOutput("fwft_empty", 32'(empty_b), 1);
    checkOutput("fwft_rdv_low", 32'(ifb.rd_valid), 0);
    checkOutput("thr_ae0", 32'(ae_b), 1);
    // Thresholds at counts 1..4: almost_empty {1,0,0,0}, almost_full {0,0,1,1}.
    for (int i = 1; i <= 4; i++) begin
      v = 8'hB0 + 8'(i);
      applyStimulus(1, 1, v, 0, 0);
      checkOutput("thr_count", 32'(count_b), i);
      checkOutput("thr_ae", 32'(ae_b), (i <= 1) ? 1 : 0);
      checkOutput("thr_af", 32'(af_b), (i >= 3) ? 1 : 0);
    end
    checkOutput("fwft_full", 32'(full_b), 1);
    checkOutput("fwft_head", 32'(ifb.rd_data), 32'hB1);
    applyStimulus(1, 0, 8'h00, 1, 0);
    checkOutput("fwft_next", 32'(ifb.rd_data), 32'hB2);
    checkOutput("fwft_cnt3", 32'(count_b), 3);

    // Registered-read instance: fill 0x11..0x55.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 1, 8'(8'h11 * i), 0, 0);
      checkOutput("fill_count", 32'(count_a), i);
    end
    checkOutput("fill_full", 32'(full_a), 1);
    checkOutput("fill_wrr", 32'(ifa.wr_ready), 0);
    // Drain with idle gaps so each rd_valid pulse is seen to last one cycle.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 8'h00, 1, 0);
      checkOutput("drain_rdv", 32'(ifa.rd_valid), 1);
      checkOutput("drain_rdd", 32'(ifa.rd_data), 32'(8'(8'h11 * i)));
      applyStimulus(0, 0, 8'h00, 0, 0);
      checkOutput("drain_pulse", 32'(ifa.rd_valid), 0);
      checkOutput("drain_hold", 32'(ifa.rd_data), 32'(8'(8'h11 * i)));
    end
    checkOutput("drain_empty", 32'(empty_a), 1);

    // Wrap: push 3 / pop 3, then push 5 starting at slot 3.
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 8'(i), 0, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 8'h00, 1, 0);
      checkOutput("wrap_rd3", 32'(ifa.rd_data), i);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 8'hA0 + 8'(i), 0, 0);
      checkOutput("wrap_count", 32'(count_a), i + 1);
    end

    // Full corner: pop happens, write rejected, overflow sets.
    applyStimulus(0, 1, 8'hEE, 1, 0);
    checkOutput("corner_full_cnt", 32'(count_a), 4);
    checkOutput("corner_full_ovf", 32'(ovf_a), 1);
    checkOutput("corner_full_rdd", 32'(ifa.rd_data), 32'hA0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 8'h00, 1, 0);
      checkOutput("wrap_rd5", 32'(ifa.rd_data), 32'(8'hA0 + 8'(i)));
    end
    checkOutput("wrap_empty", 32'(empty_a), 1);

    // Empty corner: push happens, pop does not, underflow sets.
    applyStimulus(0, 1, 8'h77, 1, 0);
    checkOutput("corner_empty_cnt", 32'(count_a), 1);
    checkOutput("corner_empty_unf", 32'(unf_a), 1);
    checkOutput("corner_empty_rdv", 32'(ifa.rd_valid), 0);

    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("clr_flags", {30'd0, ovf_a, unf_a}, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 8'h77 + 8'(i), 0, 0);
    checkOutput("refill_full", 32'(full_a), 1);
    applyStimulus(0, 1, 8'hEF, 0, 1);
    checkOutput("clr_vs_set_ovf", 32'(ovf_a), 1);
    checkOutput("clr_vs_set_cnt", 32'(count_a), 5);

    // Async reset at count 3 takes effect before the next edge.
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("pre_rst_rdd", 32'(ifa.rd_data), 32'h77);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("pre_rst_cnt", 32'(count_a), 3);
    RST = 1'b1;
    #1;
    checkOutput("mid_rst_cnt", 32'(count_a), 0);
    checkOutput("mid_rst_empty", 32'(empty_a), 1);
    checkOutput("mid_rst_rdv", 32'(ifa.rd_valid), 0);
    checkOutput("mid_rst_rdd", 32'(ifa.rd_data), 0);
    checkOutput("mid_rst_ovf", 32'(ovf_a), 0);
    RST = 1'b0;
    applyStimulus(0, 1, 8'h99, 0, 0);
    checkOutput("post_rst_cnt", 32'(count_a), 1);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("post_rst_rdd", 32'(ifa.rd_data), 32'h99);
    checkOutput("post_rst_empty", 32'(empty_a), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
